// File: rtl/dla_kpe_vec.sv
// Vector kernel processing element: operand regs -> lane dot-product -> accumulator -> shifted output.
// Define DLA_KPE_SAT_EN to clamp out-of-range results to the signed OUT_W range instead of truncating.
module dla_kpe_vec #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 32,
    parameter int SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DATA_W-1:0]  kpe_ifmap,
    input  logic [DATA_W-1:0]  kpe_weight,
    input  logic               ctrl_kpe_src0_enable,
    input  logic               ctrl_kpe_src1_enable,
    input  logic               ctrl_kpe_mul_enable,
    input  logic               ctrl_kpe_acc_enable,
    input  logic               ctrl_kpe_acc_rst,
    input  logic               ctrl_kpe_bypass,
    input  logic [SHIFT_W-1:0] stgr_precision_kpe_shift,
    input  logic [1:0]         stgr_precision_mode,
    output logic [OUT_W-1:0]   kpe_sum,
    output logic               kpe_sum_valid,
    output logic               kpe_ovf,
    output logic               kpe_sat
);

    logic [DATA_W-1:0] src0_q, src0_d, src1_q, src1_d;
    logic [ACC_W-1:0]  mul_q, mul_d, acc_q, acc_d;
    logic [OUT_W-1:0]  sum_q, sum_d;
    logic              valid_q, valid_d, ovf_q, ovf_d, sat_q, sat_d;
    logic [ACC_W-1:0]  accSum, outVal;
    logic              addOvf;
    logic [OUT_W-1:0]  outWord;
    logic              satHit;

    // Mode m splits each word into 2^m signed lanes; lane i sits at bits [(i+1)*lw-1 : i*lw].
    function automatic logic [ACC_W-1:0] laneDot(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [1:0]        mode);
        logic signed [DATA_W-1:0]   la, lb;
        logic signed [2*DATA_W-1:0] prod;
        logic [ACC_W-1:0]           sum;
        int lanes, lw;
        lanes = 1 << mode;
        lw    = DATA_W >> mode;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < lanes) begin
                la   = $signed(a << (DATA_W - lw * (i + 1))) >>> (DATA_W - lw);
                lb   = $signed(b << (DATA_W - lw * (i + 1))) >>> (DATA_W - lw);
                prod = la * lb;
                sum  = sum + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
            end
        end
        return sum;
    endfunction

    always_comb begin
        src0_d = ctrl_kpe_src0_enable ? kpe_ifmap  : src0_q;
        src1_d = ctrl_kpe_src1_enable ? kpe_weight : src1_q;

        mul_d = mul_q;
        if (ctrl_kpe_mul_enable) begin
            if (ctrl_kpe_bypass) begin
                mul_d = {{(ACC_W - DATA_W){src0_q[DATA_W-1]}}, src0_q};
            end else begin
                mul_d = laneDot(src0_q, src1_q, stgr_precision_mode);
            end
        end

        accSum = acc_q + mul_q;
        addOvf = (acc_q[ACC_W-1] == mul_q[ACC_W-1]) && (accSum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        // Bypass leaves the running sum untouched so the next MAC continues from it.
        if (!ctrl_kpe_bypass) begin
            if (ctrl_kpe_acc_rst && ctrl_kpe_acc_enable) begin
                acc_d = mul_q;
                ovf_d = 1'b0;
            end else if (ctrl_kpe_acc_rst) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end else if (ctrl_kpe_acc_enable) begin
                acc_d = accSum;
                if (addOvf) begin
                    ovf_d = 1'b1;
                end
            end
        end
        outVal = ctrl_kpe_bypass ? mul_q : acc_d;
    end

`ifdef DLA_KPE_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = $signed(outVal) >>> stgr_precision_kpe_shift;
        satHit  = 1'b1;
        if (shifted > OUT_MAX) begin
            outWord = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            outWord = OUT_MIN[OUT_W-1:0];
        end else begin
            outWord = shifted[OUT_W-1:0];
            satHit  = 1'b0;
        end
    end
`else
    always_comb begin
        outWord = OUT_W'($signed(outVal) >>> stgr_precision_kpe_shift);
        satHit  = 1'b0;
    end
`endif

    always_comb begin
        valid_d = ctrl_kpe_acc_enable;
        sum_d   = ctrl_kpe_acc_enable ? outWord : sum_q;
        sat_d   = ctrl_kpe_acc_enable ? satHit  : sat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src0_q  <= '0;
            src1_q  <= '0;
            mul_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else if (enable) begin
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            mul_q   <= mul_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    assign kpe_sum       = sum_q;
    assign kpe_sum_valid = valid_q;
    assign kpe_ovf       = ovf_q;
    assign kpe_sat       = sat_q;

endmodule
